// File: rtl/binary_adder_pkg.sv
// rtl/binary_adder_pkg.sv - shared defaults and types for the binary_adder counter
//
// Purpose: default width/reset value for binary_adder and the default-width
//          count type used by code that handles the counter value.
// Ports:   none (package).

package binary_adder_pkg;

  localparam int DEFAULT_WIDTH       = 4;
  localparam int DEFAULT_RESET_VALUE = 6;

  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : binary_adder_pkg

// File: rtl/binary_adder_half_adder.sv
// rtl/binary_adder_half_adder.sv - one-bit half adder, the cell of the ripple incrementer
//
// Purpose: sum = a ^ b, carry = a & b.
// Ports:
//   a     input  1  operand bit (counter bit)
//   b     input  1  operand bit (carry from the previous stage)
//   sum   output 1  a XOR b
//   carry output 1  a AND b

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder

// File: rtl/binary_adder.sv
// rtl/binary_adder.sv - registered +1 counter built from a half-adder ripple chain
//
// Purpose: counts rising clk edges at which increment is high, wrapping modulo
//          2^WIDTH; carry_out pulses for one cycle after a wrap to zero.
// Parameters:
//   WIDTH        counter width, 2..16
//   RESET_VALUE  value loaded into count while reset is high
// Ports:
//   clk        input  1      rising-edge clock
//   reset      input  1      asynchronous, active-high reset
//   increment  input  1      level-sampled count request
//   count      output WIDTH  current counter value (register output)
//   carry_out  output 1      registered wrap pulse

module binary_adder
  import binary_adder_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             increment,
  output logic [WIDTH-1:0] count,
  output logic             carry_out
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             carry_q;
  logic             carry_d;

  // Ripple chain: c[0] is the increment request itself, so with increment=0
  // the chain reproduces count unchanged and c[WIDTH] is 0. That makes the
  // hold case and the carry clear fall out of the arithmetic with no extra mux.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum;

  assign c[0] = increment;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
    half_adder u_ha (
      .a     (count_q[i]),
      .b     (c[i]),
      .sum   (sum[i]),
      .carry (c[i+1])
    );
  end

  always_comb begin
    count_d = sum;
    carry_d = c[WIDTH];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;

endmodule : binary_adder

// File: tb/tb_binary_adder.sv
// tb/tb_binary_adder.sv - scoreboard bench for binary_adder (default and 8-bit/250 instances)

module tb_binary_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       increment = 1'b0;
  logic [3:0] count4;
  logic       carry4;
  logic [7:0] count8;
  logic       carry8;

  always #5 clk = ~clk;

  binary_adder u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .count     (count4),
    .carry_out (carry4)
  );

  binary_adder #(.WIDTH(8), .RESET_VALUE(8'd250)) u_dut8 (
    .clk       (clk),
    .reset     (reset),
    .increment (increment),
    .count     (count8),
    .carry_out (carry8)
  );

  typedef struct {
    int c4;
    bit k4;
    int c8;
    bit k8;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   run = 0;
  event sample_ev;

  // Reference model: plain modular arithmetic on integers.
  int m4 = 6, m8 = 250;
  bit k4 = 0, k8 = 0;

  function automatic void model_reset();
    m4 = 6;   k4 = 0;
    m8 = 250; k8 = 0;
  endfunction

  function automatic void model_edge(bit rst, bit inc);
    if (rst) begin
      model_reset();
    end else if (inc) begin
      k4 = (m4 == 15);
      m4 = (m4 + 1) % 16;
      k8 = (m8 == 255);
      m8 = (m8 + 1) % 256;
    end else begin
      k4 = 0;
      k8 = 0;
    end
  endfunction

  function automatic void push_expected();
    exp_t e;
    e.c4 = m4; e.k4 = k4; e.c8 = m8; e.k8 = k8;
    sb.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Sampler: one observation point 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (run) ->sample_ev;
  end

  // Monitor: pops one expected entry per observation and compares.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty actual=0 expected=1 entries at t=%0t", $time);
      end else begin
        e = sb.pop_front();
        chk("count4", 16'(count4), 16'(e.c4));
        chk("carry4", 16'(carry4), 16'(e.k4));
        chk("count8", 16'(count8), 16'(e.c8));
        chk("carry8", 16'(carry8), 16'(e.k8));
      end
    end
  end

  // Drive one cycle: inputs change at the falling edge, expectation for the
  // following rising edge goes into the scoreboard.
  task automatic step(input bit rst, input bit inc);
    @(negedge clk);
    reset     = rst;
    increment = inc;
    run       = 1;
    model_edge(rst, inc);
    push_expected();
  endtask

  // Assert reset between edges and observe its immediate effect.
  task automatic async_reset_mid();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    push_expected();
    ->sample_ev;
  endtask

  // Pulse increment high and low without spanning a rising edge.
  task automatic glitch_pulse();
    logic saved;
    @(posedge clk);
    #2;
    saved     = increment;
    increment = 1'b1;
    #2;
    increment = saved;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset for one cycle, then hold.
    step(1, 0);
    step(0, 0);
    // Single increment, then hold for three cycles.
    step(0, 1);
    repeat (3) step(0, 0);
    // Asynchronous reset mid-cycle, then one increment from RESET_VALUE.
    async_reset_mid();
    step(0, 0);
    step(0, 1);
    // Burst through wrap: 9 edges to 15, 10th wraps with carry, 11th -> 1.
    step(1, 0);
    repeat (11) step(0, 1);
    // Hold at all-ones for five cycles.
    step(1, 0);
    repeat (9) step(0, 1);
    repeat (5) step(0, 0);
    // Wrap, then reset during the carry pulse.
    step(0, 1);
    async_reset_mid();
    // Eight-bit instance sweep 250..255 -> 0 with carry.
    step(1, 0);
    repeat (7) step(0, 1);
    step(0, 0);
    // Increment pulse that spans no rising edge.
    glitch_pulse();
    step(0, 0);
    step(0, 0);
    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) == 0), $urandom_range(0, 1) == 1);
    end
    @(posedge clk);
    #3;
    run = 0;
    chk("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_binary_adder

// File: doc/binary_adder.md
Name: binary_adder

Overview:
- Registered binary incrementing counter (a sequential "+1" adder) with a loadable reset value.
- On each rising clock edge where the increment request is high, the stored value advances by one and wraps modulo 2^WIDTH.
- It is a leaf block used as an event/step counter in small sequential datapaths. The sum is built from an explicit half-adder ripple chain, not a behavioural "+".

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- RESET_VALUE, 4'd6, value loaded into count on reset. It must fit in WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- increment  input  1  level-sampled request; each rising clk edge with increment=1 adds 1.
- count  output  WIDTH  current counter value, driven directly from a register.
- carry_out  output  1  registered one-cycle pulse, high in the cycle after count wraps from all-ones to 0.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (reset). Assertion takes effect immediately without waiting for a clock edge.
- Values while reset=1:
  - count = RESET_VALUE (6 for the default).
  - carry_out = 0.
  - increment is ignored.
- Reset deassertion is synchronous to clk. The first edge with reset=0 and increment=1 increments.
- Rising clk edge, reset=0, increment=1:
  - count <= count + 1 mod 2^WIDTH.
  - carry_out <= carry of the ripple chain: 1 only when count was all-ones, else 0.
- Rising clk edge, reset=0, increment=0: count holds; carry_out <= 0.
- Latency: one cycle. The new count is visible after the sampling edge.
- Number of increments equals the number of edges at which increment=1:
  - An increment held for N edges advances count by N.
  - A pulse that spans no rising edge has no effect.
- Wrap: all-ones + 1 -> 0 with carry_out=1 for exactly one cycle; all-ones with no increment -> hold, carry_out=0.
- Reset mid-operation: count returns to RESET_VALUE at once and any pending carry_out pulse is cleared. After reset, counting restarts from RESET_VALUE (not 0).
- Arithmetic:
  - sum[i] = count[i] XOR c[i]; c[i+1] = count[i] AND c[i]; c[0] = increment.
  - carry_out source is c[WIDTH].
- No X propagation from increment during reset. Outputs are never combinationally dependent on inputs.

Decomposition:
- Shared package binary_adder_pkg holds:
  - localparam DEFAULT_WIDTH = 4.
  - localparam DEFAULT_RESET_VALUE = 6.
  - typedef count_t as logic [DEFAULT_WIDTH-1:0].
- One sub-module, half_adder (a, b -> sum, carry), instantiated WIDTH times in a generate loop to form the ripple incrementer.
- The top level holds only the count and carry_out registers and the reset mux.

Test Plan:
- Reset: assert reset 1 cycle -> count=6, carry_out=0. Then assert reset asynchronously between edges -> count=6 immediately.
- Single increment: after reset, increment=1 across exactly one rising edge -> count=7 and stays 7 with increment=0 for 3 further cycles.
- Reset then re-increment: from count=7, pulse reset -> count=6. Then one increment edge -> count=7 (not accumulated from the prior value).
- Burst and wrap: from 6, hold increment for 9 edges:
  - count passes 7..15.
  - count=15 after 9 edges; 10th edge -> count=0 with carry_out=1 for exactly one cycle.
  - 11th edge -> count=1, carry_out=0.
- Hold at all-ones: count=15, increment=0 for 5 cycles -> count=15, carry_out=0 throughout.
- Reset during carry pulse: assert reset in the cycle carry_out=1 -> carry_out=0 and count=6 immediately. Then sweep WIDTH=8, RESET_VALUE=250 -> 250..255, then 0 with carry_out=1.
